// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit:
//   - FSM state encoding (3 bits, S_RST..S_HALT), exported on the State port
//   - instruction class produced by the decoder
//   - opcode / R-type function / ALU operation codes
//   - helper that tells whether an R-type function field is implemented
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  // FSM states. The encoding is visible on the State debug port, so keep it
  // stable.
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  // Instruction class; it selects which sequence the FSM walks.
  typedef enum logic [2:0] {
    CLS_ALU_R = 3'd0,
    CLS_ALU_I = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BR    = 3'd4,
    CLS_ILL   = 3'd5
  } cls_e;

  // Opcodes, Instr[31:26]
  localparam logic [5:0] OPC_R    = 6'b100000;
  localparam logic [5:0] OPC_LI   = 6'b111000;
  localparam logic [5:0] OPC_LUI  = 6'b111001;
  localparam logic [5:0] OPC_ADDI = 6'b110000;
  localparam logic [5:0] OPC_ANDI = 6'b110010;
  localparam logic [5:0] OPC_ORI  = 6'b110011;
  localparam logic [5:0] OPC_B    = 6'b111111;
  localparam logic [5:0] OPC_BEQ  = 6'b000000;
  localparam logic [5:0] OPC_BNE  = 6'b000001;
  localparam logic [5:0] OPC_LB   = 6'b000011;
  localparam logic [5:0] OPC_LW   = 6'b001111;
  localparam logic [5:0] OPC_SB   = 6'b000111;
  localparam logic [5:0] OPC_SW   = 6'b011111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Branch strobe vector ordering: {b, beq, bne}
  localparam logic [2:0] BR_B   = 3'b100;
  localparam logic [2:0] BR_BEQ = 3'b010;
  localparam logic [2:0] BR_BNE = 3'b001;

  // R-type function fields the datapath ALU implements. The ALU code is
  // simply func[3:0]; the upper bits only qualify legality.
  function automatic logic r_func_legal(input logic [5:0] func);
    logic legal;
    case (func)
      6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
      6'b101000, 6'b101001, 6'b101010, 6'b101100, 6'b101101: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_ctrl_if
//   Bundle between the control unit and the datapath.
//   Instr          : instruction register output fed back to the controller
//   ALU_func       : ALU operation
//   ALU_Bin_sel    : 0 = RF_B, 1 = immediate
//   RF_B_sel       : 1 = read Instr[20:16] as source B
//   RF_WrData_sel  : 0 = ALU_out, 1 = MEM_out
//   RF_WrEn        : register file write strobe
//   MEM_WrEn       : data memory write strobe
//   Mem_Out_sel    : 1 = byte load (zero-extend)
//   Mem_DataIn_sel : 1 = byte store
//   b / beq / bne  : branch strobes
//   PC_LdEn        : PC update strobe, once per retired instruction
//   Illegal        : sticky undecoded-opcode flag
//   State          : FSM state (debug)
//   master = controller side, slave = datapath side.
//   There is no valid/ready handshake on this bundle: every strobe is a
//   single-cycle qualifier that the datapath acts on at the next rising edge.
// -----------------------------------------------------------------------------
interface mips_ctrl_if;
  logic [31:0] Instr;
  logic [3:0]  ALU_func;
  logic        ALU_Bin_sel;
  logic        RF_B_sel;
  logic        RF_WrData_sel;
  logic        RF_WrEn;
  logic        MEM_WrEn;
  logic        Mem_Out_sel;
  logic        Mem_DataIn_sel;
  logic        b;
  logic        beq;
  logic        bne;
  logic        PC_LdEn;
  logic        Illegal;
  logic [2:0]  State;

  modport master (
    input  Instr,
    output ALU_func, ALU_Bin_sel, RF_B_sel, RF_WrData_sel, RF_WrEn,
           MEM_WrEn, Mem_Out_sel, Mem_DataIn_sel, b, beq, bne,
           PC_LdEn, Illegal, State
  );

  modport slave (
    output Instr,
    input  ALU_func, ALU_Bin_sel, RF_B_sel, RF_WrData_sel, RF_WrEn,
           MEM_WrEn, Mem_Out_sel, Mem_DataIn_sel, b, beq, bne,
           PC_LdEn, Illegal, State
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mips_ctrl_decode
//   Purely combinational opcode/function decoder.
//   opc, func    : in  opcode and R-type function field
//   cls          : out instruction class (ALU_R/ALU_I/LOAD/STORE/BR/ILL)
//   alu_func     : out ALU operation for the instruction
//   alu_bin_sel  : out ALU B operand comes from the immediate
//   rf_b_sel     : out register source B taken from Instr[20:16]
//   byte_op      : out lb/sb (byte-wide memory access)
//   br_sel       : out {b, beq, bne} strobe pattern for branches
// -----------------------------------------------------------------------------
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opc,
  input  logic [5:0] func,
  output cls_e       cls,
  output logic [3:0] alu_func,
  output logic       alu_bin_sel,
  output logic       rf_b_sel,
  output logic       byte_op,
  output logic [2:0] br_sel
);

  always_comb begin
    cls         = CLS_ILL;
    alu_func    = ALU_ADD;
    alu_bin_sel = 1'b0;
    rf_b_sel    = 1'b0;
    byte_op     = 1'b0;
    br_sel      = 3'b000;

    case (opc)
      OPC_R: begin
        // An unimplemented function field is as illegal as a bad opcode.
        if (r_func_legal(func)) begin
          cls      = CLS_ALU_R;
          alu_func = func[3:0];
        end
      end
      OPC_LI, OPC_LUI, OPC_ADDI: begin
        cls         = CLS_ALU_I;
        alu_bin_sel = 1'b1;
      end
      OPC_ANDI: begin
        cls         = CLS_ALU_I;
        alu_func    = ALU_AND;
        alu_bin_sel = 1'b1;
      end
      OPC_ORI: begin
        cls         = CLS_ALU_I;
        alu_func    = ALU_OR;
        alu_bin_sel = 1'b1;
      end
      OPC_B: begin
        cls    = CLS_BR;
        br_sel = BR_B;
      end
      OPC_BEQ: begin
        cls      = CLS_BR;
        alu_func = ALU_SUB;
        rf_b_sel = 1'b1;
        br_sel   = BR_BEQ;
      end
      OPC_BNE: begin
        cls      = CLS_BR;
        alu_func = ALU_SUB;
        rf_b_sel = 1'b1;
        br_sel   = BR_BNE;
      end
      OPC_LB: begin
        cls         = CLS_LOAD;
        alu_bin_sel = 1'b1;
        byte_op     = 1'b1;
      end
      OPC_LW: begin
        cls         = CLS_LOAD;
        alu_bin_sel = 1'b1;
      end
      OPC_SB: begin
        cls         = CLS_STORE;
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
        byte_op     = 1'b1;
      end
      OPC_SW: begin
        cls         = CLS_STORE;
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multi-cycle control FSM for the MIPS datapath; one instruction at a time
//   through IF/ID/EX/MEM/WB.
//   Parameters:
//     RESET_WAIT      : idle cycles after reset release before the first IF
//     HALT_ON_ILLEGAL : 1 = undecoded opcode halts, 0 = treated as a NOP
//   Ports:
//     Clk   : rising-edge clock
//     reset : asynchronous, active-low
//     bus   : mips_ctrl_if.master (Instr in, all datapath controls out)
//   Every output is decoded from flops only (state, latched opcode/func,
//   sticky illegal flag), so the async reset forces all strobes low at once.
//   The only path from Instr to an output is the NOP-mode PC_LdEn pulse in
//   S_ID, which exists only when HALT_ON_ILLEGAL = 0.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int RESET_WAIT      = 2,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        Clk,
  input  logic        reset,
  mips_ctrl_if.master bus
);

  localparam int CNT_W = 8;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [5:0]         opc_q, opc_d;
  logic [5:0]         func_q, func_d;
  logic               illegal_q, illegal_d;

  cls_e               cls;
  logic [3:0]         dec_alu_func;
  logic               dec_alu_bin_sel;
  logic               dec_rf_b_sel;
  logic               dec_byte_op;
  logic [2:0]         dec_br_sel;
  logic               wait_done;

  // Only the opcode and function fields matter to control.
  logic               instr_unused;
  assign instr_unused = ^bus.Instr[25:6];

  // ---------------------------------------------------------------------------
  // Opcode/func latch: captured while in S_ID. Outside S_ID the decoder sees
  // the held copy, so EX/MEM/WB controls never follow a changing Instr.
  // ---------------------------------------------------------------------------
  always_comb begin
    opc_d  = opc_q;
    func_d = func_q;
    if (state_q == S_ID) begin
      opc_d  = bus.Instr[31:26];
      func_d = bus.Instr[5:0];
    end
  end

  mips_ctrl_decode u_decode (
    .opc         (opc_d),
    .func        (func_d),
    .cls         (cls),
    .alu_func    (dec_alu_func),
    .alu_bin_sel (dec_alu_bin_sel),
    .rf_b_sel    (dec_rf_b_sel),
    .byte_op     (dec_byte_op),
    .br_sel      (dec_br_sel)
  );

  // The cycle on which the counter reaches RESET_WAIT-1 is the last idle one.
  assign wait_done = (int'(wait_cnt_q) + 1 >= RESET_WAIT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
      opc_q      <= '0;
      func_q     <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      opc_q      <= opc_d;
      func_q     <= func_d;
      illegal_q  <= illegal_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;

    case (state_q)
      S_RST: begin
        if (wait_done) begin
          state_d    = S_IF;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_IF: state_d = S_ID;
      S_ID: begin
        if (cls == CLS_ILL) begin
          illegal_d = 1'b1;
          state_d   = HALT_ON_ILLEGAL ? S_HALT : S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: state_d = S_WB;
          CLS_LOAD, CLS_STORE:  state_d = S_MEM;
          default:              state_d = S_IF;   // branches retire in EX
        endcase
      end
      S_MEM:   state_d = (cls == CLS_LOAD) ? S_WB : S_IF;
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;                  // left only through reset
      default: state_d = S_RST;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore)
  // ---------------------------------------------------------------------------
  logic [3:0] alu_func;
  logic       alu_bin_sel, rf_b_sel, rf_wr_data_sel, rf_wr_en;
  logic       mem_wr_en, mem_out_sel, mem_data_in_sel;
  logic [2:0] br_strobe;
  logic       pc_ld_en;

  always_comb begin
    alu_func        = 4'b0000;
    alu_bin_sel     = 1'b0;
    rf_b_sel        = 1'b0;
    rf_wr_data_sel  = 1'b0;
    rf_wr_en        = 1'b0;
    mem_wr_en       = 1'b0;
    mem_out_sel     = 1'b0;
    mem_data_in_sel = 1'b0;
    br_strobe       = 3'b000;
    pc_ld_en        = 1'b0;

    // Operand selects are held for the whole execution phase of the
    // instruction so the datapath sees stable muxes through WB/MEM.
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      alu_func    = dec_alu_func;
      alu_bin_sel = dec_alu_bin_sel;
      rf_b_sel    = dec_rf_b_sel;
    end

    case (state_q)
      S_ID: begin
        // NOP mode: retire the bad word straight from decode.
        if (!HALT_ON_ILLEGAL && cls == CLS_ILL) pc_ld_en = 1'b1;
      end
      S_EX: begin
        if (cls == CLS_BR) begin
          br_strobe = dec_br_sel;
          pc_ld_en  = 1'b1;
        end
      end
      S_MEM: begin
        if (cls == CLS_STORE) begin
          mem_wr_en       = 1'b1;
          mem_data_in_sel = dec_byte_op;
          pc_ld_en        = 1'b1;
        end
      end
      S_WB: begin
        rf_wr_en = 1'b1;
        pc_ld_en = 1'b1;
        if (cls == CLS_LOAD) begin
          rf_wr_data_sel = 1'b1;
          mem_out_sel    = dec_byte_op;
        end
      end
      default: ;
    endcase
  end

  assign bus.ALU_func       = alu_func;
  assign bus.ALU_Bin_sel    = alu_bin_sel;
  assign bus.RF_B_sel       = rf_b_sel;
  assign bus.RF_WrData_sel  = rf_wr_data_sel;
  assign bus.RF_WrEn        = rf_wr_en;
  assign bus.MEM_WrEn       = mem_wr_en;
  assign bus.Mem_Out_sel    = mem_out_sel;
  assign bus.Mem_DataIn_sel = mem_data_in_sel;
  assign bus.b              = br_strobe[2];
  assign bus.beq            = br_strobe[1];
  assign bus.bne            = br_strobe[0];
  assign bus.PC_LdEn        = pc_ld_en;
  assign bus.Illegal        = illegal_q;
  assign bus.State          = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Table of instructions with hand-derived control expectations, expanded
//   per cycle into an expected queue and compared against the DUT, plus
//   hand-written sequences for reset timing, illegal-opcode halt and reset
//   in the middle of an instruction.
//   Observed vector (19 bits): {State[2:0], ALU_func[3:0], ALU_Bin_sel,
//   RF_B_sel, RF_WrData_sel, RF_WrEn, MEM_WrEn, Mem_Out_sel, Mem_DataIn_sel,
//   b, beq, bne, PC_LdEn, Illegal}
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_ctrl_if bus ();

  mips_multicycle_ctrl #(
    .RESET_WAIT      (2),
    .HALT_ON_ILLEGAL (1'b1)
  ) dut (
    .Clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] exp_q[$];

  typedef struct {
    string      name;
    logic [5:0] opc;
    logic [5:0] func;
    logic [3:0] alu;
    logic       bin;
    logic       rfb;
    int         len;
    logic       wr;
    logic       ld;
    logic       memwr;
    logic       byte_op;
    logic [2:0] br;      // {b, beq, bne}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [5:0] o, input logic [5:0] f,
                              input logic [3:0] a, input logic bi, input logic rb,
                              input int l, input logic w, input logic ld,
                              input logic mw, input logic by, input logic [2:0] br);
    vec_t v;
    v.name = n; v.opc = o; v.func = f; v.alu = a; v.bin = bi; v.rfb = rb;
    v.len = l; v.wr = w; v.ld = ld; v.memwr = mw; v.byte_op = by; v.br = br;
    return v;
  endfunction

  function automatic logic [18:0] observe();
    return {bus.State, bus.ALU_func, bus.ALU_Bin_sel, bus.RF_B_sel, bus.RF_WrData_sel,
            bus.RF_WrEn, bus.MEM_WrEn, bus.Mem_Out_sel, bus.Mem_DataIn_sel,
            bus.b, bus.beq, bus.bne, bus.PC_LdEn, bus.Illegal};
  endfunction

  // Expected observation for cycle c (1 = IF) of instruction v.
  function automatic logic [18:0] model(input vec_t v, input int c);
    logic [15:0] o;
    logic [2:0]  st;
    o = '0;
    case (c)
      1:       st = 3'd1;
      2:       st = 3'd2;
      3:       st = 3'd3;
      4:       st = (v.ld || v.memwr) ? 3'd4 : 3'd5;
      default: st = 3'd5;
    endcase
    if (c >= 3) begin
      o[15:12] = v.alu;
      o[11]    = v.bin;
      o[10]    = v.rfb;
    end
    if (c == 3) o[4:2] = v.br;
    if (c == 4 && v.memwr) begin
      o[7] = 1'b1;
      o[5] = v.byte_op;
    end
    if (c == v.len && v.wr) o[8] = 1'b1;
    if (c == v.len && v.ld) begin
      o[9] = 1'b1;
      o[6] = v.byte_op;
    end
    if (c == v.len) o[1] = 1'b1;
    return {st, o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_if(input string name);
    int k;
    k = 0;
    while (bus.State !== 3'd1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, " reach IF"}, 32'(bus.State), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_if(v.name);
    bus.Instr = {v.opc, 20'($urandom_range(0, 20'hFFFFF)), v.func};
    for (int c = 1; c <= v.len; c++) exp_q.push_back(model(v, c));
    for (int c = 1; c <= v.len; c++) begin
      check($sformatf("%s cyc%0d", v.name, c), 32'(observe()), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int first_pc;

    //           name    opc        func       alu    bin   rfb  len wr  ld  mw  by  br
    tbl.push_back(mk("add",  OPC_R,    6'b110000, 4'h0, 0, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("sub",  OPC_R,    6'b110001, 4'h1, 0, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("r34",  OPC_R,    6'b110100, 4'h4, 0, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("r28",  OPC_R,    6'b101000, 4'h8, 0, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("r2d",  OPC_R,    6'b101101, 4'hD, 0, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("addi", OPC_ADDI, 6'b000000, 4'h0, 1, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("andi", OPC_ANDI, 6'b111111, 4'h2, 1, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("ori",  OPC_ORI,  6'b000101, 4'h3, 1, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("li",   OPC_LI,   6'b000000, 4'h0, 1, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("lui",  OPC_LUI,  6'b001100, 4'h0, 1, 0, 4, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk("lw",   OPC_LW,   6'b000000, 4'h0, 1, 0, 5, 1, 1, 0, 0, 3'b000));
    tbl.push_back(mk("lb",   OPC_LB,   6'b000000, 4'h0, 1, 0, 5, 1, 1, 0, 1, 3'b000));
    tbl.push_back(mk("sw",   OPC_SW,   6'b000000, 4'h0, 1, 1, 4, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk("sb",   OPC_SB,   6'b000000, 4'h0, 1, 1, 4, 0, 0, 1, 1, 3'b000));
    tbl.push_back(mk("b",    OPC_B,    6'b000000, 4'h0, 0, 0, 3, 0, 0, 0, 0, 3'b100));
    tbl.push_back(mk("beq",  OPC_BEQ,  6'b000000, 4'h1, 0, 1, 3, 0, 0, 0, 0, 3'b010));
    tbl.push_back(mk("bne",  OPC_BNE,  6'b000000, 4'h1, 0, 1, 3, 0, 0, 0, 0, 3'b001));

    // Reset and release timing, with an add in the instruction register.
    bus.Instr = {OPC_R, 20'h0, 6'b110000};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("in reset", 32'(observe()), 32'd0);
    rst_n = 1'b1;
    first_pc = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n <= 3) check($sformatf("post-reset idle %0d", n), 32'(observe() & 19'h0FFFF), 32'd0);
      if (first_pc == 0 && bus.PC_LdEn === 1'b1) first_pc = n;
    end
    check("first PC_LdEn cycle", 32'(first_pc), 32'd5);

    // Table-driven instruction sequences.
    foreach (tbl[i]) run_vec(tbl[i]);

    // Illegal opcode: halt with the sticky flag, no strobes afterwards.
    wait_if("ill_opc");
    bus.Instr = {6'b010101, 20'h12345, 6'b000000};
    @(negedge clk);
    check("ill_opc ID", 32'(observe()), {13'd0, 3'd2, 16'h0000});
    @(negedge clk);
    check("ill_opc HALT", 32'(observe()), {13'd0, 3'd6, 16'h0001});
    bus.Instr = {OPC_R, 20'h0, 6'b110000};
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check($sformatf("halt hold %0d", n), 32'(observe()), {13'd0, 3'd6, 16'h0001});
    end

    // Reset clears the halt and the sticky flag immediately.
    rst_n = 1'b0;
    #1;
    check("reset from HALT", 32'(observe()), 32'd0);
    @(negedge clk);
    bus.Instr = {OPC_LW, 20'h0, 6'b000000};
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("lw EX before reset", 32'(observe()), {13'd0, 3'd3, 16'h0800});
    rst_n = 1'b0;
    #1;
    check("reset during lw EX", 32'(observe()), 32'd0);
    @(negedge clk);
    check("lw held in reset", 32'(observe()), 32'd0);

    // Illegal R-type function also halts.
    bus.Instr = {OPC_R, 20'h0, 6'b111111};
    rst_n = 1'b1;
    wait_if("ill_func");
    @(negedge clk);
    @(negedge clk);
    check("ill_func HALT", 32'(observe()), {13'd0, 3'd6, 16'h0001});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
